// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_responder
// Description : Responder end of the core's data-memory bus. The low address
//               half (addr[31]==0) is a byte-writable block RAM with a
//               registered, read-first read port. The high half (addr[31]==1)
//               is memory-mapped I/O: an 8N1 UART transmitter fed by a TX FIFO
//               and a read-only status register.
//
// Ports       : clk      - system clock
//               rstn     - synchronous active-low reset
//               addr     - byte address from the core
//               din      - store data, bus lane order (lane i = din[8i+7:8i])
//               data_we  - per-lane write enable, 4'b0000 = read
//               dout     - registered read data, bus lane order
//               uart_tx  - serial output, 8N1, idle high
//
// MMIO map    : offset 0 TXDATA (write pushes din[31:24], reads 0)
//               offset 1 STATUS (read-only, byte-swapped on the bus)
//               offset 2 cycle counter when DMEM_MMIO_CYCLE_COUNTER_EN is
//                        defined, otherwise reads 0
//               offset 3 reads 0
//
// Options     : DMEM_MMIO_CYCLE_COUNTER_EN - adds a 32-bit free-running cycle
//               counter readable at MMIO offset 2.
//
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
    parameter int ADDR_W       = 14,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  data_we,
    output logic [31:0] dout,
    output logic        uart_tx
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_ptr_w:0]   c_depth     = (c_ptr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        c_st_idle  = 2'd0,
        c_st_start = 2'd1,
        c_st_data  = 2'd2,
        c_st_stop  = 2'd3
    } tx_state_t;

    // The core byte-swaps its view of the bus, so MMIO values are presented
    // swapped to reach software in logical order.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic              w_is_mmio;
    logic [ADDR_W-1:0] w_ram_idx;
    logic [1:0]        w_mmio_off;
    logic              w_store;
    logic [3:0]        w_ram_we;
    logic              w_push;

    assign w_is_mmio  = addr[31];
    assign w_ram_idx  = addr[ADDR_W+1:2];
    assign w_mmio_off = addr[3:2];
    assign w_store    = |data_we;
    assign w_ram_we   = {4{~w_is_mmio}} & data_we;

    // Store edge detection: the core may hold a store for several cycles, but
    // a TXDATA store must enqueue exactly one byte.
    logic        r_prev_store;
    logic [31:0] r_prev_addr;

    assign w_push = w_is_mmio && (w_mmio_off == 2'd0) && w_store &&
                    (!r_prev_store || (r_prev_addr != addr));

    // ------------------------------------------------------------------------
    // RAM (contents deliberately not reset)
    // ------------------------------------------------------------------------
    logic [31:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we[i]) begin
                r_mem[w_ram_idx][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               r_overflow;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= din[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_prev_store <= 1'b0;
            r_prev_addr  <= '0;
        end else begin
            r_prev_store <= w_store;
            r_prev_addr  <= addr;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // UART TX FSM (8N1, LSB first)
    // ------------------------------------------------------------------------
    tx_state_t          r_state,    w_state_nx;
    logic [c_cnt_w-1:0] r_baud_cnt, w_baud_cnt_nx;
    logic [2:0]         r_bit_idx,  w_bit_idx_nx;
    logic [7:0]         r_shift,    w_shift_nx;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= c_st_idle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_baud_cnt_nx;
            r_bit_idx  <= w_bit_idx_nx;
            r_shift    <= w_shift_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_baud_cnt_nx = r_baud_cnt;
        w_bit_idx_nx  = r_bit_idx;
        w_shift_nx    = r_shift;
        w_pop         = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nx    = r_fifo[r_rd_ptr];
                    w_baud_cnt_nx = '0;
                    w_state_nx    = c_st_start;
                end
            end
            c_st_start: begin
                if (r_baud_cnt == c_baud_last) begin
                    w_baud_cnt_nx = '0;
                    w_bit_idx_nx  = '0;
                    w_state_nx    = c_st_data;
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + 1'b1;
                end
            end
            c_st_data: begin
                if (r_baud_cnt == c_baud_last) begin
                    w_baud_cnt_nx = '0;
                    w_shift_nx    = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = c_st_stop;
                    end else begin
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + 1'b1;
                end
            end
            c_st_stop: begin
                if (r_baud_cnt == c_baud_last) begin
                    w_baud_cnt_nx = '0;
                    w_state_nx    = c_st_idle;
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = c_st_idle;
            end
        endcase
    end

    // Decoded straight from registered state so reset forces idle-high on
    // the very next cycle.
    assign uart_tx = (r_state == c_st_start) ? 1'b0 :
                     (r_state == c_st_data)  ? r_shift[0] : 1'b1;

    // ------------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------------
    logic [31:0] w_counter_rd;

`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cycle_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign w_counter_rd = bswap32(r_cycle_cnt);
`else
    assign w_counter_rd = '0;
`endif

    // ------------------------------------------------------------------------
    // Status and read mux
    // ------------------------------------------------------------------------
    logic [31:0] w_status;
    logic [31:0] w_mmio_rdata;

    always_comb begin
        w_status       = '0;
        w_status[0]    = w_full;
        w_status[1]    = (r_state != c_st_idle) || !w_empty;
        w_status[2]    = r_overflow;
        w_status[15:8] = 8'(r_count);
    end

    always_comb begin
        w_mmio_rdata = '0;
        case (w_mmio_off)
            2'd1:    w_mmio_rdata = bswap32(w_status);
            2'd2:    w_mmio_rdata = w_counter_rd;
            default: w_mmio_rdata = '0;
        endcase
    end

    // Read-first: r_mem is sampled before this edge's lane writes land.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout <= '0;
        end else if (w_is_mmio) begin
            dout <= w_mmio_rdata;
        end else begin
            dout <= r_mem[w_ram_idx];
        end
    end

endmodule
`default_nettype wire
